// File: rtl/xbar_slave_arbiter.sv
// Two-master round-robin arbiter guarding one crossbar slave port: IDLE -> ADDR -> (RDATA) -> IDLE.
// Optional ADDR-phase watchdog is compiled in when XBAR_ARB_TIMEOUT_EN is defined.
module xbar_slave_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] cmd,
  input  logic       s_ack,
  output logic [1:0] grnt,
  output logic       busy,
  output logic       rd_phase,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ADDR  = 2'b01,
    RDATA = 2'b10
  } state_e;

  state_e     state_q;
  logic [1:0] grnt_q;
  logic       last_grant_q;   // 0: master 1 was served last, 1: master 2
  logic       g_idx;
  logic       g_req;
  logic       g_cmd;
  logic [1:0] winner_d;
  logic       limit_hit;

  // grnt_q is one-hot while busy, so its upper bit is the granted master's index.
  assign g_idx = grnt_q[1];
  assign g_req = req[g_idx];
  assign g_cmd = cmd[g_idx];

  always_comb begin
    winner_d = 2'b00;
    case (req)
      2'b01:   winner_d = 2'b01;
      2'b10:   winner_d = 2'b10;
      2'b11:   winner_d = last_grant_q ? 2'b01 : 2'b10;
      default: winner_d = 2'b00;
    endcase
  end

`ifdef XBAR_ARB_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       timeout_q;

  // Hitting LIMIT-1 on a stalled ADDR cycle means this is the LIMIT-th waiting cycle.
  assign limit_hit = (cnt_q == 8'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = 8'd0;
    end else if ((state_q == ADDR) && g_req && !s_ack) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= (state_q == ADDR) && g_req && !s_ack && limit_hit;
    end
  end

  assign timeout = timeout_q;
`else
  assign limit_hit = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grnt_q       <= 2'b00;
      last_grant_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (winner_d != 2'b00) begin
            grnt_q  <= winner_d;
            state_q <= ADDR;
          end
        end
        ADDR: begin
          // A withdrawn request drops the grant without advancing the round-robin pointer.
          if (!g_req) begin
            state_q <= IDLE;
            grnt_q  <= 2'b00;
          end else if (s_ack) begin
            if (g_cmd) begin
              state_q      <= IDLE;
              grnt_q       <= 2'b00;
              last_grant_q <= g_idx;
            end else begin
              state_q <= RDATA;
            end
          end else if (limit_hit) begin
            state_q      <= IDLE;
            grnt_q       <= 2'b00;
            last_grant_q <= g_idx;
          end
        end
        RDATA: begin
          state_q      <= IDLE;
          grnt_q       <= 2'b00;
          last_grant_q <= g_idx;
        end
        default: begin
          state_q <= IDLE;
          grnt_q  <= 2'b00;
        end
      endcase
    end
  end

  assign grnt     = grnt_q;
  assign busy     = (state_q != IDLE);
  assign rd_phase = (state_q == RDATA);

endmodule

// File: tb/tb_xbar_slave_arbiter.sv
// Scoreboard bench for xbar_slave_arbiter: directed scenarios then a randomized run,
// expectations from a transaction-level ownership model of the arbitration rules.
module tb_xbar_slave_arbiter;

  localparam int TO_LIMIT = 16;
`ifdef XBAR_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req   = 2'b00;
  logic [1:0] cmd   = 2'b00;
  logic       s_ack = 1'b0;
  logic [1:0] grnt;
  logic       busy;
  logic       rd_phase;
  logic       timeout;

  xbar_slave_arbiter #(.TIMEOUT_CYCLES(TO_LIMIT)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .cmd      (cmd),
    .s_ack    (s_ack),
    .grnt     (grnt),
    .busy     (busy),
    .rd_phase (rd_phase),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] g;
    logic       b;
    logic       rd;
    logic       to;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: who owns the slave, whether the read-data beat is pending,
  // how long the owner has waited, and who was served last (1 or 2).
  int owner    = 0;
  bit in_rd    = 1'b0;
  int waited   = 0;
  int last     = 2;
  bit to_pulse = 1'b0;

  function void model_step(input bit r, input logic [1:0] rq, input logic [1:0] cm, input bit ak);
    int gi;
    to_pulse = 1'b0;
    if (r) begin
      owner  = 0;
      in_rd  = 1'b0;
      waited = 0;
      last   = 2;
      return;
    end
    if (owner == 0) begin
      if (rq == 2'b01)      owner = 1;
      else if (rq == 2'b10) owner = 2;
      else if (rq == 2'b11) owner = (last == 1) ? 2 : 1;
      waited = 0;
    end else if (in_rd) begin
      last  = owner;
      owner = 0;
      in_rd = 1'b0;
    end else begin
      gi = owner - 1;
      if (!rq[gi]) begin
        owner = 0;
      end else if (ak) begin
        if (cm[gi]) begin
          last  = owner;
          owner = 0;
        end else begin
          in_rd = 1'b1;
        end
      end else begin
        waited = waited + 1;
        if (TO_EN && waited >= TO_LIMIT) begin
          last     = owner;
          owner    = 0;
          to_pulse = 1'b1;
        end
      end
    end
  endfunction

  function exp_t model_expect(input int at);
    exp_t e;
    e.cyc = at;
    e.g   = (owner == 1) ? 2'b01 : ((owner == 2) ? 2'b10 : 2'b00);
    e.b   = (owner != 0);
    e.rd  = in_rd;
    e.to  = to_pulse;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_chk = n_chk + 1;
    if (act === req_v) n_pass = n_pass + 1;
    else $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req_v);
  endtask

  // One clock of stimulus: drive just after the edge, predict the state after the next edge.
  task automatic step(input bit r, input logic [1:0] rq, input logic [1:0] cm, input bit ak);
    exp_t e;
    @(posedge clk);
    #1;
    if (r && !reset) begin
      if (sb.size() > 0 && sb[$].cyc == cyc) begin
        e = sb.pop_back();
        check("pre_reset_outputs", 32'({grnt, busy, rd_phase, timeout}), 32'({e.g, e.b, e.rd, e.to}));
      end
      e.cyc = cyc; e.g = 2'b00; e.b = 1'b0; e.rd = 1'b0; e.to = 1'b0;
      sb.push_back(e);
      reset = 1'b1;
      #1;
      check("reset_immediate", 32'({grnt, busy, rd_phase, timeout}), 32'd0);
    end
    reset = r;
    req   = rq;
    cmd   = cm;
    s_ack = ak;
    model_step(r, rq, cm, ak);
    sb.push_back(model_expect(cyc + 1));
  endtask

  logic [1:0] prev_g = 2'b00;
  logic       prev_b = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      check("stale_expectation", 32'(cyc), 32'(e.cyc));
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      check("outputs_grnt_busy_rd_to", 32'({grnt, busy, rd_phase, timeout}), 32'({e.g, e.b, e.rd, e.to}));
    end
    if (grnt != 2'b00) check("grnt_not_both", 32'(grnt == 2'b11), 32'd0);
    if (prev_b && busy) check("grnt_stable_while_busy", 32'(grnt), 32'(prev_g));
    if (prev_g != 2'b00 && grnt != prev_g)
      $display("txn cyc=%0d master=%0d released%s", cyc, prev_g[1] ? 2 : 1, timeout ? " by timeout" : "");
    prev_g = grnt;
    prev_b = busy;
  end

  initial begin
    #1;
    check("reset_state", 32'({grnt, busy, rd_phase, timeout}), 32'd0);
    step(1'b1, 2'b00, 2'b00, 1'b0);
    step(1'b1, 2'b00, 2'b00, 1'b0);

    // Master 1 write, slave acks in the second ADDR cycle.
    step(1'b0, 2'b01, 2'b01, 1'b0);
    step(1'b0, 2'b01, 2'b01, 1'b0);
    step(1'b0, 2'b01, 2'b01, 1'b1);
    step(1'b0, 2'b00, 2'b00, 1'b0);
    step(1'b0, 2'b00, 2'b00, 1'b0);

    // Both masters reading with a zero-wait slave: grants alternate.
    step(1'b1, 2'b00, 2'b00, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 2'b11, 2'b00, 1'b1);
    step(1'b0, 2'b00, 2'b00, 1'b0);

    // Withdrawn request leaves the pointer at master 2, so master 1 wins the tie.
    step(1'b1, 2'b00, 2'b00, 1'b0);
    step(1'b0, 2'b10, 2'b00, 1'b0);
    step(1'b0, 2'b00, 2'b00, 1'b0);
    step(1'b0, 2'b11, 2'b00, 1'b0);
    step(1'b0, 2'b00, 2'b00, 1'b0);

    // Reset lands in RDATA, then master 1 wins again after release.
    step(1'b1, 2'b00, 2'b00, 1'b0);
    step(1'b0, 2'b11, 2'b00, 1'b1);
    step(1'b0, 2'b11, 2'b00, 1'b1);
    step(1'b1, 2'b11, 2'b00, 1'b1);
    step(1'b1, 2'b11, 2'b00, 1'b1);
    step(1'b0, 2'b11, 2'b00, 1'b0);
    step(1'b0, 2'b00, 2'b00, 1'b0);

`ifdef XBAR_ARB_TIMEOUT_EN
    // Stalled slave: watchdog fires after TO_LIMIT ADDR cycles, then master 2 wins the tie.
    step(1'b1, 2'b00, 2'b00, 1'b0);
    for (int i = 0; i < TO_LIMIT + 1; i++) step(1'b0, 2'b01, 2'b00, 1'b0);
    step(1'b0, 2'b11, 2'b00, 1'b0);
    step(1'b0, 2'b11, 2'b00, 1'b1);
    step(1'b0, 2'b00, 2'b00, 1'b0);
    // Ack in the very cycle the limit is reached still completes the write.
    step(1'b0, 2'b01, 2'b01, 1'b0);
    for (int i = 0; i < TO_LIMIT - 1; i++) step(1'b0, 2'b01, 2'b01, 1'b0);
    step(1'b0, 2'b01, 2'b01, 1'b1);
    step(1'b0, 2'b00, 2'b00, 1'b0);
`endif

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 2) != 0));
    end
    step(1'b0, 2'b00, 2'b00, 1'b0);
    step(1'b0, 2'b00, 2'b00, 1'b0);
    step(1'b0, 2'b00, 2'b00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/xbar_slave_arbiter.md
XBAR_SLAVE_ARBITER -- requirements
Module: xbar_slave_arbiter

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT_CYCLES, default 16, the ADDR-state cycle limit before abort; legal range 2..255.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port req, input, 2, per-master request already decoded for this slave (addr[31] match); bit0 = master 1, bit1 = master 2.
REQ-005 The block SHALL have port cmd, input, 2, per-master command, 1 = write, 0 = read.
REQ-006 The block SHALL have port s_ack, input, 1, slave acknowledge of the granted transfer.
REQ-007 The block SHALL have port grnt, output, 2, registered one-hot grant (00 = none) steering crossbar muxes.
REQ-008 The block SHALL have port busy, output, 1, high whenever the FSM is not IDLE.
REQ-009 The block SHALL have port rd_phase, output, 1, high during the read-data return cycle.
REQ-010 The block SHALL have port timeout, output, 1, one-cycle abort pulse.

Function
REQ-011 The FSM SHALL have states IDLE, ADDR and RDATA; grnt is 00 only in IDLE and never has both bits set.
REQ-012 In IDLE with req != 00, the next edge SHALL load grnt with the winner and enter ADDR (grant latency one cycle).
REQ-013 The winner SHALL be the single requester; on req = 11 it is the master not recorded in last_grant.
REQ-014 In ADDR, s_ack=1 with req[g]=1 and cmd[g]=1 (write) SHALL return to IDLE next edge with grnt=00 and last_grant=g.
REQ-015 In ADDR, s_ack=1 with req[g]=1 and cmd[g]=0 (read) SHALL enter RDATA, holding grnt.
REQ-016 RDATA SHALL last exactly one cycle with rd_phase=1 and grnt held, then go to IDLE with last_grant=g.
REQ-017 In ADDR, req[g]=0 without s_ack SHALL return to IDLE with last_grant unchanged (withdrawn request, no pointer advance).
REQ-018 s_ack SHALL be ignored in IDLE and RDATA.
REQ-019 Grant SHALL never move while busy; the other master's req is only evaluated in IDLE, so at least one IDLE cycle separates consecutive grants.
REQ-020 s_ack in the first ADDR cycle SHALL be honoured (zero-wait slave).
REQ-021 busy SHALL be decoded combinationally from the state register; rd_phase SHALL equal (state == RDATA).

Reset
REQ-022 Asserting reset SHALL immediately force state=IDLE, grnt=00, busy=0, rd_phase=0, timeout=0, last_grant=master 2 (master 1 wins the first tie), timeout counter=0.
REQ-023 Reset asserted mid-transfer SHALL abort the transfer without a timeout pulse; the first grant after deassertion follows REQ-012.

Configuration
REQ-024 With macro XBAR_ARB_TIMEOUT_EN defined, an 8-bit counter SHALL clear on ADDR entry, increment each ADDR cycle without s_ack, and on reaching TIMEOUT_CYCLES force IDLE, pulse timeout for one cycle and set last_grant=g.
REQ-025 Without XBAR_ARB_TIMEOUT_EN, the counter SHALL be absent, timeout tied to 0, and ADDR waits indefinitely for s_ack or req withdrawal.
REQ-026 s_ack in the same cycle the limit is reached SHALL win over timeout.

Verification
REQ-027 Reset release, req=01 cmd=01, s_ack on 2nd ADDR cycle -> grnt=01 one cycle after req, back to 00 one cycle after ack, rd_phase never high.
REQ-028 req=11 cmd=00 held, s_ack=1 always -> grants alternate 01,10,01 each as ADDR(1 cycle)+RDATA(1 cycle), one IDLE cycle between, rd_phase high once per grant.
REQ-029 req=10 granted, req drops to 00 before ack, then req=11 -> grnt=00 next cycle, then grnt=01 (last_grant still master 2 from reset).
REQ-030 XBAR_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, req=01, s_ack=0 -> timeout pulse after 16 ADDR cycles, grnt=00; with req=11 the next grant is 10.
REQ-031 reset asserted during RDATA with req=11 -> grnt=00 and rd_phase=0 same cycle; after release grnt=01.
REQ-032 Any random req/cmd/s_ack run -> grnt never 11, grnt stable while busy.
